// File: rtl/health_pkg.sv
// Shared types and default constants for the fighter health bars.
// Imported by the ghost tracker and the bar animator top.
package health_pkg;

    localparam int BAR_LEN_DEF      = 245;
    localparam int HEALTH_W_DEF     = 8;
    localparam int X_LEFT_DEF       = 50;
    localparam int X_RIGHT_DEF      = 590;
    localparam int Y_TOP_DEF        = 34;
    localparam int Y_BOT_DEF        = 48;
    localparam int HOLD_FRAMES_DEF  = 30;
    localparam int DRAIN_STEP_DEF   = 2;
    localparam int LOW_THRESH_DEF   = 49;
    localparam int BLINK_FRAMES_DEF = 8;

    typedef enum logic [1:0] {
        CODE_NONE  = 2'b00,
        CODE_LIVE  = 2'b01,
        CODE_GHOST = 2'b10,
        CODE_FLASH = 2'b11
    } bar_code_e;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_HOLD  = 2'd1,
        GS_DRAIN = 2'd2
    } ghost_state_e;

    function automatic logic [10:0] clamp_h(input logic [31:0] h, input int lim);
        if (h > 32'(lim)) return 11'(lim);
        return 11'(h);
    endfunction

endpackage

// File: rtl/health_ghost_tracker.sv
// Per-player ghost level: holds the old health after a hit,
// then drains toward the live health once per frame.
module health_ghost_tracker
    import health_pkg::*;
#(
    parameter int BAR_LEN     = BAR_LEN_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int DRAIN_STEP  = DRAIN_STEP_DEF
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [10:0] health,
    output logic [10:0] ghost,
    output logic        busy
);

    localparam logic [10:0] FULL    = 11'(BAR_LEN);
    localparam logic [10:0] STEP    = 11'(DRAIN_STEP);
    localparam logic [15:0] HOLD_LD = 16'(HOLD_FRAMES);

    ghost_state_e state, state_n;
    logic [15:0]  hold, hold_n;
    logic [10:0]  ghost_n, prev_h, gap;
    logic         hit;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= GS_IDLE;
            hold   <= 16'd0;
            ghost  <= FULL;
            prev_h <= FULL;
        end else begin
            state  <= state_n;
            hold   <= hold_n;
            ghost  <= ghost_n;
            prev_h <= health;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        ghost_n = ghost;
        gap     = ghost - health;
        hit     = health < prev_h;
        // a heal snaps the ghost up regardless of state
        if (health > ghost) begin
            ghost_n = health;
            state_n = GS_IDLE;
        end else begin
            unique case (state)
                GS_IDLE: begin
                    if (health < ghost) begin
                        hold_n  = HOLD_LD;
                        state_n = GS_HOLD;
                    end
                end
                GS_HOLD: begin
                    if (hit) begin
                        hold_n = HOLD_LD;
                    end else if (frame_tick) begin
                        if (hold == 16'd0) state_n = GS_DRAIN;
                        else               hold_n  = hold - 16'd1;
                    end
                end
                GS_DRAIN: begin
                    if (hit) begin
                        hold_n  = HOLD_LD;
                        state_n = GS_HOLD;
                    end else if (ghost == health) begin
                        state_n = GS_IDLE;
                    end else if (frame_tick) begin
                        ghost_n = ghost - ((gap < STEP) ? gap : STEP);
                    end
                end
                default: state_n = GS_IDLE;
            endcase
        end
    end

    assign busy = (state != GS_IDLE);

endmodule

// File: rtl/health_bar_animator.sv
// Draws two mirrored health bars with a draining ghost segment
// and a low-health flash on the live segment.
module health_bar_animator
    import health_pkg::*;
#(
    parameter int BAR_LEN      = BAR_LEN_DEF,
    parameter int HEALTH_W     = HEALTH_W_DEF,
    parameter int X_LEFT       = X_LEFT_DEF,
    parameter int X_RIGHT      = X_RIGHT_DEF,
    parameter int Y_TOP        = Y_TOP_DEF,
    parameter int Y_BOT        = Y_BOT_DEF,
    parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF,
    parameter int DRAIN_STEP   = DRAIN_STEP_DEF,
    parameter int LOW_THRESH   = LOW_THRESH_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [HEALTH_W-1:0] RyuHealth,
    input  logic [HEALTH_W-1:0] AkumaHealth,
    input  logic                blank,
    output logic [1:0]          bar_code,
    output logic                health_on,
    output logic [1:0]          drain_busy
);

    localparam logic [10:0] XL  = 11'(X_LEFT);
    localparam logic [10:0] XR  = 11'(X_RIGHT);
    localparam logic [10:0] YT  = 11'(Y_TOP);
    localparam logic [10:0] YB  = 11'(Y_BOT);
    localparam logic [10:0] LOW = 11'(LOW_THRESH);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic        at_origin, origin_q, frame_tick;
    logic [10:0] ryu_h, akuma_h, ryu_g, akuma_g, x, y;
    logic        l_busy, r_busy, in_y, l_live, l_ghost, r_live, r_ghost;
    logic        l_low, r_low, phase;
    logic [15:0] frame_cnt;
    bar_code_e   code_d, code_q;

    assign ryu_h   = clamp_h(32'(RyuHealth), BAR_LEN);
    assign akuma_h = clamp_h(32'(AkumaHealth), BAR_LEN);

    // one tick on the first cycle the scan reaches the origin
    assign at_origin  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick = at_origin && !origin_q;

    health_ghost_tracker #(
        .BAR_LEN(BAR_LEN), .HOLD_FRAMES(HOLD_FRAMES), .DRAIN_STEP(DRAIN_STEP)
    ) u_left (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .health(ryu_h), .ghost(ryu_g), .busy(l_busy)
    );

    health_ghost_tracker #(
        .BAR_LEN(BAR_LEN), .HOLD_FRAMES(HOLD_FRAMES), .DRAIN_STEP(DRAIN_STEP)
    ) u_right (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .health(akuma_h), .ghost(akuma_g), .busy(r_busy)
    );

    assign x       = {1'b0, DrawX};
    assign y       = {1'b0, DrawY};
    assign in_y    = (y >= YT) && (y < YB);
    assign l_live  = in_y && (x >= XL) && (x < XL + ryu_h);
    assign l_ghost = in_y && (x >= XL + ryu_h) && (x < XL + ryu_g);
    assign r_live  = in_y && (x >= XR - akuma_h) && (x < XR);
    assign r_ghost = in_y && (x >= XR - akuma_g) && (x < XR - akuma_h);
    assign l_low   = (ryu_h != 11'd0) && (ryu_h <= LOW);
    assign r_low   = (akuma_h != 11'd0) && (akuma_h <= LOW);

    always_comb begin
        code_d = CODE_NONE;
        if (l_live)
            code_d = (l_low && phase) ? CODE_FLASH : CODE_LIVE;
        else if (r_live)
            code_d = (r_low && phase) ? CODE_FLASH : CODE_LIVE;
        else if (l_ghost || r_ghost)
            code_d = CODE_GHOST;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            origin_q  <= 1'b0;
            frame_cnt <= 16'd0;
            phase     <= 1'b0;
            code_q    <= CODE_NONE;
            health_on <= 1'b0;
        end else begin
            origin_q <= at_origin;
            if (frame_tick) begin
                if (frame_cnt == BLINK_LAST) begin
                    frame_cnt <= 16'd0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
            code_q    <= blank ? code_d : CODE_NONE;
            health_on <= blank && (code_d != CODE_NONE);
        end
    end

    assign bar_code   = code_q;
    assign drain_busy = {r_busy, l_busy};

endmodule

// File: tb/tb_health_bar_animator.sv
// Directed bench: pixel table plus ghost, blink and reset sequences.
module tb_health_bar_animator;
    import health_pkg::*;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] DrawX = 10'd1, DrawY = 10'd1;
    logic [7:0] RyuHealth = 8'd245, AkumaHealth = 8'd245;
    logic       blank = 1'b1;
    logic [1:0] bar_code, drain_busy;
    logic       health_on;

    int checks = 0;
    int failures = 0;

    health_bar_animator dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(DrawX), .DrawY(DrawY),
        .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth),
        .blank(blank), .bar_code(bar_code),
        .health_on(health_on), .drain_busy(drain_busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0] dx;
        logic [9:0] dy;
        logic       blk;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame();
        DrawX = 10'd0; DrawY = 10'd0;
        cyc();
        DrawX = 10'd1; DrawY = 10'd1;
        cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        reset_n = 1'b1;
    endtask

    task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic b);
        DrawX = px; DrawY = py; blank = b;
        cyc();
    endtask

    initial begin
        int exp_g;
        logic exp_ph;

        vecs[0]  = '{10'd60,  10'd40, 1'b1, 2'b01};
        vecs[1]  = '{10'd50,  10'd40, 1'b1, 2'b01};
        vecs[2]  = '{10'd49,  10'd40, 1'b1, 2'b00};
        vecs[3]  = '{10'd149, 10'd40, 1'b1, 2'b01};
        vecs[4]  = '{10'd150, 10'd40, 1'b1, 2'b10};
        vecs[5]  = '{10'd294, 10'd40, 1'b1, 2'b10};
        vecs[6]  = '{10'd295, 10'd40, 1'b1, 2'b00};
        vecs[7]  = '{10'd345, 10'd40, 1'b1, 2'b01};
        vecs[8]  = '{10'd344, 10'd40, 1'b1, 2'b00};
        vecs[9]  = '{10'd589, 10'd40, 1'b1, 2'b01};
        vecs[10] = '{10'd590, 10'd40, 1'b1, 2'b00};
        vecs[11] = '{10'd400, 10'd33, 1'b1, 2'b00};
        vecs[12] = '{10'd400, 10'd48, 1'b1, 2'b00};
        vecs[13] = '{10'd400, 10'd47, 1'b1, 2'b01};
        vecs[14] = '{10'd400, 10'd34, 1'b1, 2'b01};
        vecs[15] = '{10'd60,  10'd40, 1'b0, 2'b00};

        // reset state, with a left hit and a clamped right input pending
        RyuHealth = 8'd100; AkumaHealth = 8'd255;
        DrawX = 10'd60; DrawY = 10'd40;
        repeat (2) @(posedge vga_clk);
        #1;
        chk("rst_code", 32'(bar_code), 0);
        chk("rst_on", 32'(health_on), 0);
        chk("rst_busy", 32'(drain_busy), 0);
        chk("rst_ghost_l", 32'(dut.u_left.ghost), 245);
        chk("rst_ghost_r", 32'(dut.u_right.ghost), 245);
        @(negedge vga_clk);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 16; i++) begin
            pixel(vecs[i].dx, vecs[i].dy, vecs[i].blk);
            chk($sformatf("vec%0d_code", i), 32'(bar_code), 32'(vecs[i].code));
            chk($sformatf("vec%0d_on", i), 32'(health_on), 32'(vecs[i].code != 2'b00));
        end
        chk("tbl_busy", 32'(drain_busy), 1);

        // hit 245 -> 200: hold then drain
        RyuHealth = 8'd245; AkumaHealth = 8'd245;
        do_reset();
        RyuHealth = 8'd200;
        cyc();
        chk("hit_busy", 32'(drain_busy), 1);
        chk("hit_state", 32'(dut.u_left.state), 32'(GS_HOLD));
        repeat (30) frame();
        chk("hold30_ghost", 32'(dut.u_left.ghost), 245);
        chk("hold30_state", 32'(dut.u_left.state), 32'(GS_HOLD));
        frame();
        chk("drain_enter", 32'(dut.u_left.state), 32'(GS_DRAIN));
        chk("drain_enter_g", 32'(dut.u_left.ghost), 245);
        exp_g = 245;
        for (int n = 1; n <= 23; n++) begin
            frame();
            exp_g -= ((exp_g - 200) < 2) ? (exp_g - 200) : 2;
            chk($sformatf("drain%0d", n), 32'(dut.u_left.ghost), 32'(exp_g));
        end
        chk("drain_done_busy", 32'(drain_busy), 0);

        // heal snaps the ghost up
        RyuHealth = 8'd240;
        cyc();
        chk("heal_ghost", 32'(dut.u_left.ghost), 240);
        chk("heal_state", 32'(dut.u_left.state), 32'(GS_IDLE));

        // re-hit during drain at ghost 220
        RyuHealth = 8'd180;
        cyc();
        repeat (31) frame();
        repeat (10) frame();
        chk("pre_rehit_g", 32'(dut.u_left.ghost), 220);
        chk("pre_rehit_st", 32'(dut.u_left.state), 32'(GS_DRAIN));
        RyuHealth = 8'd150;
        cyc();
        chk("rehit_state", 32'(dut.u_left.state), 32'(GS_HOLD));
        chk("rehit_ghost", 32'(dut.u_left.ghost), 220);
        repeat (30) frame();
        chk("rehold_state", 32'(dut.u_left.state), 32'(GS_HOLD));
        chk("rehold_ghost", 32'(dut.u_left.ghost), 220);
        frame();
        chk("redrain_state", 32'(dut.u_left.state), 32'(GS_DRAIN));
        frame();
        chk("redrain_ghost", 32'(dut.u_left.ghost), 218);

        // low health flash, half-period 8 frames
        RyuHealth = 8'd40;
        do_reset();
        pixel(10'd60, 10'd40, 1'b1);
        chk("flash_p0", 32'(bar_code), 1);
        exp_ph = 1'b0;
        for (int p = 0; p < 4; p++) begin
            repeat (7) frame();
            pixel(10'd60, 10'd40, 1'b1);
            chk($sformatf("flash_mid%0d", p), 32'(bar_code), exp_ph ? 3 : 1);
            frame();
            exp_ph = ~exp_ph;
            pixel(10'd60, 10'd40, 1'b1);
            chk($sformatf("flash_p%0d", p + 1), 32'(bar_code), exp_ph ? 3 : 1);
            pixel(10'd60, 10'd40, 1'b0);
            chk($sformatf("flash_blank%0d", p), 32'(bar_code), 0);
        end

        // async reset mid-hold, then re-arm on release
        RyuHealth = 8'd245;
        do_reset();
        RyuHealth = 8'd200;
        pixel(10'd60, 10'd40, 1'b1);
        pixel(10'd60, 10'd40, 1'b1);
        chk("pre_arst_code", 32'(bar_code), 1);
        chk("pre_arst_busy", 32'(drain_busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_code", 32'(bar_code), 0);
        chk("arst_on", 32'(health_on), 0);
        chk("arst_busy", 32'(drain_busy), 0);
        chk("arst_ghost", 32'(dut.u_left.ghost), 245);
        @(negedge vga_clk);
        reset_n = 1'b1;
        cyc();
        chk("rearm_busy", 32'(drain_busy), 1);
        chk("rearm_ghost", 32'(dut.u_left.ghost), 245);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/health_bar_animator.md
HEALTH_BAR_ANIMATOR -- requirements
Module: health_bar_animator

Interface
REQ-001 SHALL have parameter BAR_LEN, default 245, meaning full-health bar length in pixels and the clamp value for health inputs.
REQ-002 SHALL have parameter HEALTH_W, default 8, meaning the width of each health input.
REQ-003 SHALL have parameters X_LEFT=50, X_RIGHT=590, Y_TOP=34, Y_BOT=48, meaning the left-bar anchor, the right-bar anchor, and the vertical span [Y_TOP,Y_BOT).
REQ-004 SHALL have parameter HOLD_FRAMES, default 30, meaning the frames the ghost bar is held after damage.
REQ-005 SHALL have parameter DRAIN_STEP, default 2, meaning the ghost decrement in pixels per frame.
REQ-006 SHALL have parameter LOW_THRESH, default 49, meaning the health at or below which the live bar flashes.
REQ-007 SHALL have parameter BLINK_FRAMES, default 8, meaning the frames per flash half-period.
REQ-008 SHALL have port vga_clk, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports DrawX and DrawY, input, 10 bits each: the current pixel coordinates.
REQ-011 SHALL have ports RyuHealth and AkumaHealth, input, HEALTH_W bits each: the target health of the left and right player.
REQ-012 SHALL have port blank, input, 1 bit: high means the pixel is in the visible region.
REQ-013 SHALL have port bar_code, output, 2 bits: 00 none, 01 live, 10 ghost, 11 live-flash.
REQ-014 SHALL have port health_on, output, 1 bit: high when bar_code is not 00.
REQ-015 SHALL have port drain_busy, output, 2 bits: bit0 high while the left ghost is not IDLE, bit1 the same for the right ghost.

Function
REQ-016 SHALL clamp each health input to BAR_LEN before any use.
REQ-017 SHALL assert an internal frame_tick for exactly one cycle on the first cycle on which (DrawX,DrawY) becomes (0,0).
REQ-018 SHALL track one ghost level per player using states IDLE, HOLD and DRAIN.
REQ-019 In IDLE, if health < ghost, SHALL load the hold counter with HOLD_FRAMES and enter HOLD.
REQ-020 In HOLD, each frame_tick SHALL decrement the hold counter; on a tick with the counter at 0, SHALL enter DRAIN.
REQ-021 Any health decrease during HOLD or DRAIN SHALL reload the hold counter and enter HOLD, leaving ghost unchanged.
REQ-022 In DRAIN, each frame_tick SHALL set ghost to ghost - min(DRAIN_STEP, ghost - health); when ghost equals health, SHALL enter IDLE.
REQ-023 If health > ghost in any state, SHALL set ghost to health on the next cycle and enter IDLE; this rule has priority over REQ-019 to REQ-022.
REQ-024 Left-bar pixel classes: live when X_LEFT <= DrawX < X_LEFT+health; ghost when X_LEFT+health <= DrawX < X_LEFT+ghost.
REQ-025 Right-bar pixel classes: live when X_RIGHT-health <= DrawX < X_RIGHT; ghost when X_RIGHT-ghost <= DrawX < X_RIGHT-health.
REQ-026 Both bars SHALL additionally require Y_TOP <= DrawY < Y_BOT; all compares SHALL use 11-bit unsigned arithmetic (no wrap).
REQ-027 SHALL toggle a blink phase every BLINK_FRAMES frame_ticks.
REQ-028 A live pixel SHALL be coded 11 when 0 < health <= LOW_THRESH and the blink phase is 1, and 01 otherwise.
REQ-029 SHALL register bar_code and health_on with 1-cycle latency from DrawX/DrawY, forcing 00 when blank is low.

Reset
REQ-030 reset_n low SHALL asynchronously set bar_code=00, health_on=0, drain_busy=00, both ghosts=BAR_LEN, both states=IDLE, hold counters=0, blink phase=0 and frame counter=0.
REQ-031 Reset deasserted mid-drain SHALL resume from IDLE with ghost=BAR_LEN; REQ-019 then re-arms HOLD on the first cycle.

Structure
REQ-032 A shared package health_pkg SHALL hold the bar_code enum, the ghost state enum and the default constants.
REQ-033 Per-player ghost logic SHALL be the sub-module health_ghost_tracker, instantiated twice.

Verification
REQ-034 Health drop: health 245->200 at frame 0 -> ghost holds 245 for 30 frames, then drains 2 per frame, reaches 200 about 23 frames later, and drain_busy clears.
REQ-035 Re-hit during DRAIN at ghost=220, health ->150 -> HOLD restarts with ghost=220, and DRAIN resumes after 30 frames.
REQ-036 Heal: health 100 (ghost 180) ->245 -> ghost=245 next cycle, state IDLE.
REQ-037 RyuHealth=40: pixel (60,40) with blank=1 -> bar_code alternates 01/11 every 8 frames; with blank=0 -> 00.
REQ-038 Clamp and edge: AkumaHealth=255 -> live for DrawX 345..589 and none at 344 and 590; Y=33 and Y=48 give none.
REQ-039 reset_n asserted mid-HOLD -> all outputs 00 immediately, without a clock edge.
